pps_pulse_synchronisor: RTL and testbench



---
 rtl/pps_pulse_synchronisor.sv | 156 +++++++++++++++
 tb/tb_pps_pulse_synchronisor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pps_pulse_synchronisor.sv
// PPS-disciplined sample strobe: synchronises 1PPS, emits PULSE_RATE_HZ strobes phase-aligned
// to it, tracks lock against the nominal second and free-runs through short PPS outages.
module pps_pulse_synchronisor #(
  parameter int CLK_FREQ_HZ    = 3276800,
  parameter int PULSE_RATE_HZ  = 50,
  parameter int SYNC_STAGES    = 2,
  parameter int PPS_TOL_CYCLES = 64,
  parameter int MISS_LIMIT     = 3,
  localparam int IDX_W = (PULSE_RATE_HZ > 1) ? $clog2(PULSE_RATE_HZ) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             PPS_IN,
  input  logic             ENABLE,
  output logic             PULSE,
  output logic [IDX_W-1:0] PULSE_IDX,
  output logic             PPS_EDGE,
  output logic             LOCKED,
  output logic             HOLDOVER,
  output logic             PPS_ERR
);

  localparam int PERIOD = CLK_FREQ_HZ / PULSE_RATE_HZ;
  localparam int SUB_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int GAP_HI = CLK_FREQ_HZ + PPS_TOL_CYCLES;
  localparam int GAP_LO = CLK_FREQ_HZ - PPS_TOL_CYCLES;
  localparam int GAP_W  = $clog2(GAP_HI + 2) + 1;
  localparam int MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

  generate
    if (CLK_FREQ_HZ % PULSE_RATE_HZ != 0) begin : g_bad_rate
      $fatal(1, "CLK_FREQ_HZ must be an integer multiple of PULSE_RATE_HZ");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_VERIFY, S_LOCKED, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               pps_q, pps_edge_q, pps_err_q;
  logic [SUB_W-1:0]   sub_cnt;
  logic [IDX_W-1:0]   idx_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               realign, err_nxt, run_nxt, running;
  logic               sub_wrap, idx_wrap, in_tol, gap_timeout;

  // Edge detect sits behind the synchroniser; PPS_EDGE is held off while disabled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_q     <= '0;
      pps_q      <= 1'b0;
      pps_edge_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], PPS_IN};
      pps_q      <= sync_q[SYNC_STAGES-1];
      pps_edge_q <= ENABLE & sync_q[SYNC_STAGES-1] & ~pps_q;
    end
  end

  assign sub_wrap    = (sub_cnt == SUB_W'(PERIOD - 1));
  assign idx_wrap    = sub_wrap && (idx_cnt == IDX_W'(PULSE_RATE_HZ - 1));
  assign in_tol      = (gap_cnt >= GAP_W'(GAP_LO)) && (gap_cnt <= GAP_W'(GAP_HI));
  assign gap_timeout = (gap_cnt == GAP_W'(GAP_HI + 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // The edge is tested before the timeout so a coincident edge always wins.
  always_comb begin
    state_nxt = state;
    realign   = 1'b0;
    err_nxt   = 1'b0;
    if (!ENABLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_ACQ;
        S_ACQ: if (pps_edge_q) begin
          realign   = 1'b1;
          state_nxt = S_VERIFY;
        end
        S_VERIFY, S_LOCKED: begin
          if (pps_edge_q) begin
            realign = 1'b1;
            if (in_tol) state_nxt = S_LOCKED;
            else begin
              err_nxt   = 1'b1;
              state_nxt = S_VERIFY;
            end
          end else if (gap_timeout) begin
            err_nxt   = 1'b1;
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (pps_edge_q) begin
            realign   = 1'b1;
            state_nxt = S_VERIFY;
          end else if (idx_wrap && miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
            state_nxt = S_ACQ;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    run_nxt = (state_nxt == S_VERIFY) || (state_nxt == S_LOCKED) || (state_nxt == S_HOLD);
  end

  always_comb begin
    running   = (state == S_VERIFY) || (state == S_LOCKED) || (state == S_HOLD);
    PULSE     = running && (sub_cnt == '0);
    PULSE_IDX = idx_cnt;
    PPS_EDGE  = pps_edge_q;
    LOCKED    = (state == S_LOCKED);
    HOLDOVER  = (state == S_HOLD);
    PPS_ERR   = pps_err_q;
  end

  // A PPS on the natural wrap lands on sub_cnt==0 either way, so only one strobe results.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sub_cnt <= '0;
      idx_cnt <= '0;
    end else if (!run_nxt || realign) begin
      sub_cnt <= '0;
      idx_cnt <= '0;
    end else if (sub_wrap) begin
      sub_cnt <= '0;
      idx_cnt <= idx_wrap ? '0 : idx_cnt + 1'b1;
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      gap_cnt   <= '0;
      miss_cnt  <= '0;
      pps_err_q <= 1'b0;
    end else begin
      pps_err_q <= err_nxt;
      if (!run_nxt)             gap_cnt <= '0;
      else if (realign)         gap_cnt <= GAP_W'(1);
      else if (gap_cnt != '1)   gap_cnt <= gap_cnt + 1'b1;
      if (state != S_HOLD || state_nxt != S_HOLD) miss_cnt <= '0;
      else if (idx_wrap)                          miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pps_pulse_synchronisor.sv
// Scoreboard bench: stimulus queues expected strobes/edges/errors, a negedge monitor pops and checks.
module tb_pps_pulse_synchronisor;

  logic       CLK = 1'b0, nRST = 1'b0, PPS_IN = 1'b0, ENABLE = 1'b1;
  logic       PULSE, PPS_EDGE, LOCKED, HOLDOVER, PPS_ERR;
  logic [3:0] PULSE_IDX;

  int cyc = 0, errors = 0, checks = 0, pulses_seen = 0;

  typedef struct packed {int c; logic [3:0] idx; logic lk; logic ho;} pexp_t;
  pexp_t pq[$];
  int    eq[$];
  int    rq[$];

  pps_pulse_synchronisor #(
    .CLK_FREQ_HZ(1000), .PULSE_RATE_HZ(10), .SYNC_STAGES(2),
    .PPS_TOL_CYCLES(4), .MISS_LIMIT(2)
  ) dut (
    .CLK(CLK), .nRST(nRST), .PPS_IN(PPS_IN), .ENABLE(ENABLE),
    .PULSE(PULSE), .PULSE_IDX(PULSE_IDX), .PPS_EDGE(PPS_EDGE),
    .LOCKED(LOCKED), .HOLDOVER(HOLDOVER), .PPS_ERR(PPS_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pps(input int n);
    goto(n);
    PPS_IN = 1'b1;
    goto(n + 20);
    PPS_IN = 1'b0;
  endtask

  task automatic push_p(input int c0, input int idx0, input int n, input logic lk, input logic ho);
    for (int i = 0; i < n; i++) begin
      pexp_t e;
      e.c = c0 + 100 * i; e.idx = 4'((idx0 + i) % 10); e.lk = lk; e.ho = ho;
      pq.push_back(e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulse"}, int'(PULSE), 0);
    chk({tag, "_idx"}, int'(PULSE_IDX), 0);
    chk({tag, "_edge"}, int'(PPS_EDGE), 0);
    chk({tag, "_locked"}, int'(LOCKED), 0);
    chk({tag, "_holdover"}, int'(HOLDOVER), 0);
    chk({tag, "_err"}, int'(PPS_ERR), 0);
  endtask

  // Monitor: every strobe, edge and error the DUT presents must match the head of its queue.
  initial forever begin
    @(negedge CLK);
    if (PULSE) begin
      pulses_seen++;
      if (pq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse at cycle %0d idx %0d, required no pulse", cyc, PULSE_IDX);
      end else begin
        pexp_t e;
        e = pq.pop_front();
        chk("pulse_cycle", cyc, e.c);
        chk("pulse_idx", int'(PULSE_IDX), int'(e.idx));
        chk("pulse_locked", int'(LOCKED), int'(e.lk));
        chk("pulse_holdover", int'(HOLDOVER), int'(e.ho));
      end
    end
    if (PPS_EDGE) begin
      if (eq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pps_edge at cycle %0d, required none", cyc);
      end else chk("pps_edge_cycle", cyc, eq.pop_front());
    end
    if (PPS_ERR) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pps_err at cycle %0d, required none", cyc);
      end else chk("pps_err_cycle", cyc, rq.pop_front());
    end
  end

  initial begin
    // Reset held while PPS toggles
    goto(2); PPS_IN = 1'b1;
    goto(3); chk_zero("rst_a");
    goto(4); PPS_IN = 1'b0;
    goto(5); PPS_IN = 1'b1;
    goto(6); chk_zero("rst_b");
    goto(7); PPS_IN = 1'b0;
    goto(10); nRST = 1'b1;
    goto(199);
    chk("pulses_before_pps", pulses_seen, 0);

    // Acquire, verify, lock
    eq.push_back(203);  push_p(204, 0, 10, 1'b0, 1'b0);
    pps(200);
    eq.push_back(1203); push_p(1204, 0, 11, 1'b1, 1'b0);
    pps(1200);
    // Jitter inside and just outside tolerance
    eq.push_back(2206); push_p(2207, 0, 11, 1'b1, 1'b0);
    pps(2203);
    goto(2300); chk("locked_after_gap1003", int'(LOCKED), 1);
    eq.push_back(3211); rq.push_back(3212); push_p(3212, 0, 10, 1'b0, 1'b0);
    pps(3208);
    goto(3300); chk("locked_after_gap1005", int'(LOCKED), 0);
    eq.push_back(4211); push_p(4212, 0, 11, 1'b1, 1'b0);
    // PPS lost: holdover, two wraps, back to acquire
    rq.push_back(5217); push_p(5312, 1, 19, 1'b0, 1'b1);
    pps(4208);
    goto(5216); chk("locked_before_timeout", int'(LOCKED), 1);
    chk("holdover_before_timeout", int'(HOLDOVER), 0);
    goto(5217); chk("locked_at_timeout", int'(LOCKED), 0);
    chk("holdover_at_timeout", int'(HOLDOVER), 1);
    goto(7211); chk("holdover_before_giveup", int'(HOLDOVER), 1);
    goto(7212); chk("holdover_after_giveup", int'(HOLDOVER), 0);

    // Reacquire, lock, lose PPS again, recover from holdover
    eq.push_back(7503); push_p(7504, 0, 10, 1'b0, 1'b0);
    pps(7500);
    eq.push_back(8503); push_p(8504, 0, 11, 1'b1, 1'b0);
    rq.push_back(9509); push_p(9604, 1, 1, 1'b0, 1'b1);
    pps(8500);
    eq.push_back(9703); push_p(9704, 0, 10, 1'b0, 1'b0);
    pps(9700);
    chk("holdover_after_recover", int'(HOLDOVER), 0);
    chk("locked_after_recover", int'(LOCKED), 0);
    eq.push_back(10703); push_p(10704, 0, 3, 1'b1, 1'b0);
    pps(10700);
    goto(10710); chk("relocked", int'(LOCKED), 1);

    // Mid-second async reset
    goto(10950);
    nRST = 1'b0;
    #1 chk_zero("async_rst");
    goto(10960); nRST = 1'b1;

    // Enable drop and restore
    eq.push_back(11003); push_p(11004, 0, 2, 1'b0, 1'b0);
    pps(11000);
    goto(11150); chk("idx_before_disable", int'(PULSE_IDX), 1);
    ENABLE = 1'b0;
    goto(11151); chk_zero("disabled");
    goto(11200); ENABLE = 1'b1;
    eq.push_back(11503); push_p(11504, 0, 2, 1'b0, 1'b0);
    pps(11500);
    goto(11700);

    chk("pending_pulses", pq.size(), 0);
    chk("pending_edges", eq.size(), 0);
    chk("pending_errs", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
